// File: rtl/cello_tt_sweep_ctrl.sv
// cello_tt_sweep_ctrl
// Sweeps every input row of a small combinational gate netlist. Each row is
// held for SETTLE_CYCLES cycles and then sampled for one cycle. The observed
// truth table is then compared against TRUTH_TABLE.
// Truth tables are MSB-first: row r lives in bit (2**N_IN-1-r).
//
// Ports:
//   clk       single clock
//   rst       asynchronous active-high reset
//   start     request a sweep (accepted in IDLE only)
//   abort     cancel a sweep at once; wins over start
//   dut_in    input vector driven to the netlist (= current row index)
//   dut_out   netlist output, asynchronous to clk (2-flop synchronised)
//   busy      sweep in progress
//   done      one-cycle pulse on sweep completion (never on abort)
//   pass      observed matches TRUTH_TABLE (valid from done onward)
//   observed  collected truth table
//   mismatch  observed XOR TRUTH_TABLE
module cello_tt_sweep_ctrl #(
    parameter int                   N_IN          = 3,
    parameter logic [(2**N_IN)-1:0] TRUTH_TABLE   = 8'h61,
    parameter int                   SETTLE_CYCLES = 16,
    parameter int                   CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   observed,
    output logic [(2**N_IN)-1:0]   mismatch
);

    localparam logic [N_IN-1:0]  ROW_LAST = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Reject parameter sets that cannot work.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("cello_tt_sweep_ctrl: SETTLE_CYCLES must be >= 3");
        end
        if ((2**CNT_W) < SETTLE_CYCLES) begin : g_bad_cnt_w
            $error("cello_tt_sweep_ctrl: CNT_W too small for SETTLE_CYCLES");
        end
        if ((N_IN < 1) || (N_IN > 4)) begin : g_bad_n_in
            $error("cello_tt_sweep_ctrl: N_IN must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [N_IN-1:0]        row_r, row_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   sync1_r, sync2_r;
    logic [N_IN-1:0]        dut_in_s;
    logic                   busy_s, done_s, pass_s;
    logic [(2**N_IN)-1:0]   observed_s, mismatch_s;

    // Two-flop synchroniser for the asynchronous netlist output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= dut_out;
            sync2_r <= sync1_r;
        end
    end

    // Next-state and next-output logic. Every output is registered, so
    // dut_in changes only on a clock edge, once per row.
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        cnt_s      = cnt_r;
        dut_in_s   = dut_in;
        busy_s     = busy;
        done_s     = 1'b0;
        pass_s     = pass;
        observed_s = observed;
        mismatch_s = mismatch;

        if (abort) begin
            state_s    = ST_IDLE;
            row_s      = '0;
            cnt_s      = '0;
            dut_in_s   = '0;
            busy_s     = 1'b0;
            pass_s     = 1'b0;
            observed_s = '0;
            mismatch_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_s   = 1'b0;
                    dut_in_s = '0;
                    if (start) begin
                        state_s    = ST_SETTLE;
                        row_s      = '0;
                        cnt_s      = '0;
                        observed_s = '0;
                        mismatch_s = '0;
                        pass_s     = 1'b0;
                        busy_s     = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    busy_s   = 1'b1;
                    dut_in_s = row_r;
                    cnt_s    = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_SAMPLE;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    // ~row_r is the MSB-first bit position of this row.
                    observed_s[~row_r] = sync2_r;
                    if (row_r == ROW_LAST) begin
                        state_s    = ST_DONE;
                        done_s     = 1'b1;
                        busy_s     = 1'b0;
                        dut_in_s   = '0;
                        mismatch_s = observed_s ^ TRUTH_TABLE;
                        pass_s     = (observed_s == TRUTH_TABLE);
                    end else begin
                        state_s  = ST_SETTLE;
                        row_s    = row_r + N_IN'(1);
                        cnt_s    = '0;
                        dut_in_s = row_r + N_IN'(1);
                    end
                end
                ST_DONE: begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    dut_in_s = '0;
                end
                default: begin
                    state_s    = ST_IDLE;
                    row_s      = '0;
                    cnt_s      = '0;
                    dut_in_s   = '0;
                    busy_s     = 1'b0;
                    pass_s     = 1'b0;
                    observed_s = '0;
                    mismatch_s = '0;
                end
            endcase
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            row_r    <= '0;
            cnt_r    <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            observed <= '0;
            mismatch <= '0;
        end else begin
            state_r  <= state_s;
            row_r    <= row_s;
            cnt_r    <= cnt_s;
            dut_in   <= dut_in_s;
            busy     <= busy_s;
            done     <= done_s;
            pass     <= pass_s;
            observed <= observed_s;
            mismatch <= mismatch_s;
        end
    end

endmodule

// File: tb/tb_cello_tt_sweep_ctrl.sv
// Testbench for cello_tt_sweep_ctrl.
// Instance a uses the default parameters. Its dut_out comes either from the
// 0x61 gate equation or from an arbitrary lookup table.
// Instance b uses SETTLE_CYCLES=3. Its dut_out comes from the gate equation
// through a delay line of selectable length.
`timescale 1ns/1ps
module tb_cello_tt_sweep_ctrl;

    localparam int          ROWS    = 8;
    localparam int          ROW_CYC = 17;            // SETTLE_CYCLES + 1
    localparam int          DONE_AT = ROWS * ROW_CYC;
    localparam int          DONE_B  = ROWS * 4;      // SETTLE_CYCLES=3
    localparam logic [7:0]  TT      = 8'h61;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, abort_a, start_b, abort_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] observed_a, mismatch_a, observed_b, mismatch_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference netlist; in1 is the MSB of the input vector.
    function automatic logic gate_fn(input logic [2:0] v);
        return (v[2] & v[1] & v[0]) | (~v[2] & (v[1] ^ v[0]));
    endfunction

    logic       use_gate;
    logic [7:0] net_tt;
    logic [2:0] idx_a;
    assign idx_a     = 3'd7 - dut_in_a;
    assign dut_out_a = use_gate ? gate_fn(dut_in_a) : net_tt[idx_a];

    // Delay line clocked on the falling edge. With length L, the output
    // settles L-0.5 cycles after dut_in changes.
    logic [7:0] dline = 8'h00;
    int         dly_len;
    always @(negedge clk) dline <= {dline[6:0], gate_fn(dut_in_b)};
    assign dut_out_b = dline[dly_len-1];

    cello_tt_sweep_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .observed(observed_a), .mismatch(mismatch_a)
    );

    cello_tt_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .observed(observed_b), .mismatch(mismatch_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: with a zero-delay netlist, row r reads back as the
    // netlist value for input r, stored MSB-first.
    function automatic logic [7:0] model_obs(input logic g, input logic [7:0] t);
        logic [7:0] o;
        logic [2:0] rv;
        o = 8'h00;
        for (int r = 0; r < ROWS; r++) begin
            rv = 3'(r);
            o[7-r] = g ? gate_fn(rv) : t[3'd7 - rv];
        end
        return o;
    endfunction

    // A full sweep on instance a. If repulse_k >= 1, start is also held high
    // in the cycle before edge repulse_k.
    task automatic sweep_a(input string tag, input int repulse_k,
                           input logic [7:0] e_obs, input logic [7:0] e_mis, input logic e_pass);
        int         done_k, done_cnt, din_err, busy_err, trans;
        logic [2:0] prev;
        done_k = -1; done_cnt = 0; din_err = 0; busy_err = 0; trans = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk({tag, " start_clears_observed"}, observed_a, 0);
        chk({tag, " start_clears_pass"}, pass_a, 0);
        prev = dut_in_a;
        for (int k = 1; k <= DONE_AT + 20; k++) begin
            if (k == repulse_k) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            if (dut_in_a != prev) trans++;
            prev = dut_in_a;
            if (done_a) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k < DONE_AT) begin
                if (dut_in_a != 3'(k / ROW_CYC)) din_err++;
                if (busy_a != 1'b1) busy_err++;
            end else begin
                if (dut_in_a != 3'd0) din_err++;
                if (busy_a != 1'b0) busy_err++;
            end
        end
        chk({tag, " done_cycle"}, done_k, DONE_AT);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " dut_in_errors"}, din_err, 0);
        chk({tag, " busy_errors"}, busy_err, 0);
        chk({tag, " dut_in_transitions"}, trans, ROWS);
        chk({tag, " observed"}, observed_a, e_obs);
        chk({tag, " mismatch"}, mismatch_a, e_mis);
        chk({tag, " pass"}, pass_a, e_pass);
    endtask

    // A full sweep on instance b with the chosen delay-line length.
    task automatic sweep_b(input string tag, input int len, input logic e_pass, input logic e_mis_nz);
        int done_k;
        done_k = -1;
        dly_len = len;
        repeat (10) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 1; k <= DONE_B + 10; k++) begin
            @(posedge clk); #1;
            if (done_b && done_k < 0) done_k = k;
        end
        chk({tag, " done_cycle"}, done_k, DONE_B);
        chk({tag, " pass"}, pass_b, e_pass);
        chk({tag, " mismatch_nonzero"}, (mismatch_b != 8'h00), e_mis_nz);
    endtask

    typedef struct {
        string      name;
        logic       use_gate;
        logic [7:0] net_tt;
        int         repulse_k;
        logic [7:0] exp_obs;
        logic [7:0] exp_mis;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen, busy_seen;
        logic [7:0] t, e;

        vecs[0] = '{"gate61",    1'b1, 8'h00, -1,  8'h61, 8'h00, 1'b1};
        vecs[1] = '{"stuck0",    1'b0, 8'h00, 50,  8'h00, 8'h61, 1'b0};
        vecs[2] = '{"stuck1",    1'b0, 8'hFF, 137, 8'hFF, 8'h9E, 1'b0};
        vecs[3] = '{"table61",   1'b0, 8'h61, 1,   8'h61, 8'h00, 1'b1};
        vecs[4] = '{"row7wrong", 1'b0, 8'h60, -1,  8'h60, 8'h01, 1'b0};

        rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        use_gate = 1'b1; net_tt = 8'h00; dly_len = 1;
        #1;
        chk("reset_dut_in", dut_in_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_pass_obs_mis", {pass_a, observed_a, mismatch_a}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Fixed vectors.
        for (int i = 0; i < 5; i++) begin
            use_gate = vecs[i].use_gate;
            net_tt   = vecs[i].net_tt;
            sweep_a(vecs[i].name, vecs[i].repulse_k, vecs[i].exp_obs, vecs[i].exp_mis, vecs[i].exp_pass);
        end

        // Random netlist functions, checked against the model.
        for (int i = 0; i < 6; i++) begin
            use_gate = 1'b0;
            t = 8'($urandom);
            if (i == 0) t = TT;
            net_tt = t;
            e = model_obs(1'b0, t);
            sweep_a($sformatf("rand%0d", i), int'($urandom_range(1, 137)), e, e ^ TT, e == TT);
        end

        // Abort while row 4 is settling.
        use_gate = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4 * ROW_CYC + 5) @(posedge clk);
        #1;
        chk("abort_pre_dut_in", dut_in_a, 4);
        chk("abort_pre_observed", observed_a, model_obs(1'b1, 8'h00) & 8'hF0);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_dut_in", dut_in_a, 0);
        chk("abort_observed", observed_a, 0);
        chk("abort_pass_mis", {pass_a, mismatch_a}, 0);
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < DONE_AT + 10; k++) begin
            @(posedge clk); #1;
            if (done_a) done_seen++;
            if (busy_a) busy_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_stays_idle", busy_seen, 0);
        sweep_a("after_abort", -1, 8'h61, 8'h00, 1'b1);

        // start together with abort in IDLE.
        start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; abort_a = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (busy_a) busy_seen++;
        end
        chk("start_abort_idle_busy", busy_seen, 0);
        chk("start_abort_clears_obs", observed_a, 0);

        // Asynchronous reset in the middle of a settle period.
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_pre_dut_in", dut_in_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_busy", busy_a, 0);
        chk("rst_async_dut_in", dut_in_a, 0);
        chk("rst_async_done_pass", {done_a, pass_a}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) done_seen++;
        end
        chk("rst_no_done_or_busy", done_seen, 0);
        sweep_a("after_rst", -1, 8'h61, 8'h00, 1'b1);

        // Delay tolerance with SETTLE_CYCLES=3.
        sweep_b("delay2", 2, 1'b1, 1'b0);
        sweep_b("delay5", 5, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cello_tt_sweep_ctrl.md
Name: cello_tt_sweep_ctrl

Overview:
Sequencer that exhaustively exercises one small N-input combinational gate netlist (NOR/NOT Cello-style design, default 3-input function 0x61). It drives every input row in turn and waits a programmable settle time per row. It then samples the synchronised netlist output and compares the collected truth table against the expected hex value. The block sits beside the netlist under test and is controlled by a start/abort handshake from the test host.

Parameters:
N_IN, 3, number of netlist inputs (1..4); rows = 2**N_IN
TRUTH_TABLE, 8'h61, expected function, width 2**N_IN, MSB-first: row r = input vector r expects bit TRUTH_TABLE[2**N_IN-1-r]
SETTLE_CYCLES, 16, cycles each row is held before sampling; must be >= 3 (elaboration error otherwise)
CNT_W, 8, settle counter width; must satisfy 2**CNT_W >= SETTLE_CYCLES

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a sweep; sampled in IDLE only
abort  in  1  terminate sweep immediately; priority over start
dut_in  out  N_IN  input vector to netlist; {MSB..LSB} = row index r
dut_out  in  1  netlist output; asynchronous to clk, synchronised internally
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep completes (not on abort)
pass  out  1  observed == TRUTH_TABLE; valid from done until next start/abort
observed  out  2**N_IN  collected truth table, same MSB-first convention
mismatch  out  2**N_IN  observed XOR TRUTH_TABLE

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; dut_in=0, busy=0, done=0, pass=0, observed=0, mismatch=0, counter=0, sync flops=0.
- dut_out passes through a 2-flop synchroniser. The sampled value is the synchroniser output.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. If start=1 and abort=0: row=0, dut_in=0, counter=0, observed=0, mismatch=0, pass=0, then go to SETTLE.
- SETTLE: busy=1, dut_in=row. Counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle): observed[2**N_IN-1-row] <= sync_out.
  - If row == 2**N_IN-1, go to DONE.
  - Otherwise row++, counter=0, go to SETTLE. dut_in changes on this edge.
- DONE (1 cycle): done=1, busy=0, dut_in=0. pass and mismatch are computed from the final observed and registered on entry to DONE. Then go to IDLE.
- Row cost is SETTLE_CYCLES+1 cycles. done is high in the cycle after edge number rows*(SETTLE_CYCLES+1), counting the start-sampling edge as 0. Defaults give 136.
- start while busy or in DONE is ignored and not queued.
- abort=1 in any state: next state IDLE, dut_in=0, busy=0, pass=0, observed/mismatch cleared, no done pulse. abort and start in the same IDLE cycle: stays IDLE.
- Async reset mid-sweep: immediate return to reset values. No done pulse.
- Outputs observed/mismatch/pass hold after DONE until the next accepted start or an abort.
- dut_in is glitch-free: driven directly from a register, one transition per row.

Test Plan:
- Default params, model 0x61 netlist (out = in1&in2&in3 | ~in1&(in2^in3)), pulse start -> dut_in steps 0..7, 17 cycles per row; done at cycle 136; observed=8'h61, mismatch=0, pass=1.
- Stuck-at-0 output -> observed=8'h00, mismatch=8'h61, pass=0, done still at 136.
- Model with 2-cycle output delay, SETTLE_CYCLES=3 -> pass=1. Same model with 5-cycle delay -> pass=0 and mismatch nonzero.
- abort asserted while row=4 in SETTLE -> next cycle IDLE, dut_in=0, busy=0, observed=0, no done pulse. New start completes normally.
- start re-pulsed during sweep and start+abort together in IDLE -> both ignored; done pulses once at 136 and state stays IDLE respectively.
- rst asserted asynchronously mid-SETTLE (between edges) -> outputs zero immediately. After release, a start gives a full correct sweep.
